// File: rtl/video_blend_sched.sv
// Frame-synchronous scheduler for the playfield blend alpha/enable controls.
// Optional irq_o/irq_ack_i handshake is built when VIDEO_BLEND_SCHED_IRQ_EN is defined.
module video_blend_sched #(
    parameter logic VSYNC_POL = 1'b1,
    parameter int   ALPHA_W   = 4,
    parameter int   RATE_W    = 4
) (
    input  logic               clk,
    input  logic               reset_n_i,
    input  logic               vsync_i,
    input  logic               cfg_wr_i,
    input  logic               cfg_blend_en_i,
    input  logic [ALPHA_W-1:0] cfg_target_i,
    input  logic [RATE_W-1:0]  cfg_rate_i,
`ifdef VIDEO_BLEND_SCHED_IRQ_EN
    input  logic               irq_ack_i,
    output logic               irq_o,
`endif
    output logic               cfg_pending_o,
    output logic               blend_en_o,
    output logic [ALPHA_W-1:0] alpha_o,
    output logic               fade_busy_o,
    output logic               fade_done_o
);

    typedef enum logic {IDLE, FADING} state_t;

    // One step toward the target; clamps at the range ends instead of wrapping.
    function automatic logic [ALPHA_W-1:0] step_toward(input logic [ALPHA_W-1:0] cur,
                                                       input logic [ALPHA_W-1:0] tgt);
        logic [ALPHA_W-1:0] res;
        res = cur;
        if (cur < tgt && cur != {ALPHA_W{1'b1}})
            res = cur + ALPHA_W'(1);
        else if (cur > tgt && cur != {ALPHA_W{1'b0}})
            res = cur - ALPHA_W'(1);
        return res;
    endfunction

    state_t             state_q;
    logic               vsync_q;
    logic               pend_q;
    logic               pend_en_q;
    logic [ALPHA_W-1:0] pend_target_q;
    logic [RATE_W-1:0]  pend_rate_q;
    logic               blend_en_q;
    logic [ALPHA_W-1:0] target_q;
    logic [RATE_W-1:0]  rate_q;
    logic [ALPHA_W-1:0] alpha_q;
    logic [RATE_W-1:0]  frame_cnt_q;
    logic               done_q;

    logic               vs_act;
    logic               vs_edge;
    logic [ALPHA_W-1:0] alpha_d;

    assign vs_act  = (vsync_i == VSYNC_POL);
    assign vs_edge = vs_act & ~vsync_q;
    assign alpha_d = step_toward(alpha_q, target_q);

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= IDLE;
            vsync_q       <= 1'b0;
            pend_q        <= 1'b0;
            pend_en_q     <= 1'b0;
            pend_target_q <= '0;
            pend_rate_q   <= '0;
            blend_en_q    <= 1'b0;
            target_q      <= '0;
            rate_q        <= '0;
            alpha_q       <= '0;
            frame_cnt_q   <= '0;
            done_q        <= 1'b0;
        end else begin
            vsync_q <= vs_act;
            done_q  <= 1'b0;

            // A write on an apply edge becomes the next pending set; the old set is applied below.
            if (cfg_wr_i) begin
                pend_q        <= 1'b1;
                pend_en_q     <= cfg_blend_en_i;
                pend_target_q <= cfg_target_i;
                pend_rate_q   <= cfg_rate_i;
            end else if (vs_edge && pend_q) begin
                pend_q <= 1'b0;
            end

            if (vs_edge && pend_q) begin
                blend_en_q <= pend_en_q;
                target_q   <= pend_target_q;
                rate_q     <= pend_rate_q;
                if (pend_rate_q == '0 || alpha_q == pend_target_q) begin
                    alpha_q <= pend_target_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    frame_cnt_q <= pend_rate_q;
                    state_q     <= FADING;
                end
            end else if (vs_edge && state_q == FADING) begin
                if (frame_cnt_q > RATE_W'(1)) begin
                    frame_cnt_q <= frame_cnt_q - RATE_W'(1);
                end else begin
                    alpha_q     <= alpha_d;
                    frame_cnt_q <= rate_q;
                    if (alpha_d == target_q) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            end
        end
    end

`ifdef VIDEO_BLEND_SCHED_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i)
            irq_q <= 1'b0;
        else if (done_q)
            irq_q <= 1'b1;
        else if (irq_ack_i)
            irq_q <= 1'b0;
    end

    assign irq_o = irq_q;
`endif

    assign cfg_pending_o = pend_q;
    assign blend_en_o    = blend_en_q;
    assign alpha_o       = alpha_q;
    assign fade_busy_o   = (state_q == FADING);
    assign fade_done_o   = done_q;

endmodule

// File: tb/tb_video_blend_sched.sv
// Directed bench for video_blend_sched: config capture, vsync-aligned apply, ramps, abort, reset.
module tb_video_blend_sched;

    logic       clk;
    logic       reset_n_i;
    logic       vsync_i;
    logic       cfg_wr_i;
    logic       cfg_blend_en_i;
    logic [3:0] cfg_target_i;
    logic [3:0] cfg_rate_i;
    logic       cfg_pending_o;
    logic       blend_en_o;
    logic [3:0] alpha_o;
    logic       fade_busy_o;
    logic       fade_done_o;
`ifdef VIDEO_BLEND_SCHED_IRQ_EN
    logic       irq_ack_i;
    logic       irq_o;
`endif

    int checks;
    int errors;
    int done_cnt;

    video_blend_sched #(.VSYNC_POL(1'b1), .ALPHA_W(4), .RATE_W(4)) dut (
        .clk            (clk),
        .reset_n_i      (reset_n_i),
        .vsync_i        (vsync_i),
        .cfg_wr_i       (cfg_wr_i),
        .cfg_blend_en_i (cfg_blend_en_i),
        .cfg_target_i   (cfg_target_i),
        .cfg_rate_i     (cfg_rate_i),
`ifdef VIDEO_BLEND_SCHED_IRQ_EN
        .irq_ack_i      (irq_ack_i),
        .irq_o          (irq_o),
`endif
        .cfg_pending_o  (cfg_pending_o),
        .blend_en_o     (blend_en_o),
        .alpha_o        (alpha_o),
        .fade_busy_o    (fade_busy_o),
        .fade_done_o    (fade_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (fade_done_o) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input int hold);
        vsync_i = 1'b1;
        tick(hold);
        vsync_i = 1'b0;
        tick(4);
    endtask

    task automatic cfg_write(input logic en, input logic [3:0] tgt, input logic [3:0] rate);
        cfg_blend_en_i = en;
        cfg_target_i   = tgt;
        cfg_rate_i     = rate;
        cfg_wr_i       = 1'b1;
        tick(1);
        cfg_wr_i       = 1'b0;
        tick(2);
    endtask

    logic [3:0] exp_ramp [7];
    logic [3:0] exp_up   [4];

    initial begin
        checks = 0; errors = 0; done_cnt = 0;
        reset_n_i = 1'b0; vsync_i = 1'b0; cfg_wr_i = 1'b0;
        cfg_blend_en_i = 1'b0; cfg_target_i = '0; cfg_rate_i = '0;
`ifdef VIDEO_BLEND_SCHED_IRQ_EN
        irq_ack_i = 1'b0;
`endif
        tick(3);
        check("rst_alpha", alpha_o, 0);
        check("rst_en", blend_en_o, 0);
        check("rst_busy", fade_busy_o, 0);
        check("rst_pending", cfg_pending_o, 0);
        check("rst_done", fade_done_o, 0);
`ifdef VIDEO_BLEND_SCHED_IRQ_EN
        check("rst_irq", irq_o, 0);
`endif
        reset_n_i = 1'b1;
        tick(2);
        repeat (3) frame(1);
        check("idle_alpha", alpha_o, 0);
        check("idle_en", blend_en_o, 0);
        check("idle_busy", fade_busy_o, 0);
        check("idle_done_cnt", done_cnt, 0);

        // Immediate jump (rate 0), applied only at the vsync edge
        cfg_write(1'b1, 4'd9, 4'd0);
        check("jump_pending", cfg_pending_o, 1);
        check("jump_alpha_before", alpha_o, 0);
        done_cnt = 0;
        vsync_i = 1'b1;
        tick(1);
        check("jump_alpha", alpha_o, 9);
        check("jump_en", blend_en_o, 1);
        check("jump_done_pulse", fade_done_o, 1);
        check("jump_pending_clr", cfg_pending_o, 0);
        vsync_i = 1'b0;
        tick(4);
        check("jump_done_cnt", done_cnt, 1);
        check("jump_done_low", fade_done_o, 0);
`ifdef VIDEO_BLEND_SCHED_IRQ_EN
        check("irq_set", irq_o, 1);
        tick(3);
        check("irq_hold", irq_o, 1);
        irq_ack_i = 1'b1;
        tick(1);
        irq_ack_i = 1'b0;
        check("irq_ack", irq_o, 0);
`endif

        // Ramp down 9 -> 6, one step every 2 frames
        exp_ramp = '{4'd9, 4'd9, 4'd8, 4'd8, 4'd7, 4'd7, 4'd6};
        cfg_write(1'b1, 4'd6, 4'd2);
        done_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            frame(1);
            check($sformatf("down_alpha_%0d", i), alpha_o, exp_ramp[i]);
            check($sformatf("down_busy_%0d", i), fade_busy_o, (i < 6) ? 1 : 0);
        end
        check("down_done_cnt", done_cnt, 1);

        // Start a ramp 6 -> 10, then abort at 8 with two back-to-back writes
        cfg_write(1'b1, 4'd10, 4'd1);
        frame(1);
        check("up_apply_alpha", alpha_o, 6);
        frame(1);
        frame(1);
        check("pre_abort_alpha", alpha_o, 8);
        done_cnt = 0;
        cfg_write(1'b0, 4'd0, 4'd3);
        cfg_write(1'b1, 4'd12, 4'd1);
        frame(1);
        check("abort_alpha", alpha_o, 8);
        check("abort_busy", fade_busy_o, 1);
        check("abort_en_second", blend_en_o, 1);
        exp_up = '{4'd9, 4'd10, 4'd11, 4'd12};
        for (int i = 0; i < 4; i++) begin
            frame(1);
            check($sformatf("up_alpha_%0d", i), alpha_o, exp_up[i]);
        end
        check("up_busy_end", fade_busy_o, 0);
        check("up_done_cnt", done_cnt, 1);

        // Write coincident with the vsync edge while nothing is pending
        cfg_blend_en_i = 1'b1; cfg_target_i = 4'd2; cfg_rate_i = 4'd1;
        cfg_wr_i = 1'b1; vsync_i = 1'b1;
        tick(1);
        cfg_wr_i = 1'b0; vsync_i = 1'b0;
        check("coinc_alpha", alpha_o, 12);
        check("coinc_pending", cfg_pending_o, 1);
        tick(4);
        check("coinc_busy", fade_busy_o, 0);
        frame(1);
        check("coinc_apply_alpha", alpha_o, 12);
        check("coinc_apply_busy", fade_busy_o, 1);
        frame(500);
        check("long_vsync_alpha", alpha_o, 11);
        repeat (6) frame(1);
        check("pre_reset_alpha", alpha_o, 5);
        check("pre_reset_busy", fade_busy_o, 1);

        // Asynchronous reset mid-cycle during a ramp
        done_cnt = 0;
        #2 reset_n_i = 1'b0;
        #1;
        check("arst_alpha", alpha_o, 0);
        check("arst_busy", fade_busy_o, 0);
        check("arst_en", blend_en_o, 0);
        check("arst_pending", cfg_pending_o, 0);
        tick(2);
        check("arst_done_cnt", done_cnt, 0);
        reset_n_i = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
